// File: rtl/cp0_unit_pkg.sv
// ============================================================================
//  Module      : cp0_unit_pkg
//  Description : Shared CP0 register numbers, field positions and codes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cp0_unit_pkg;

    localparam logic [4:0]  c_reg_sr    = 5'd12;
    localparam logic [4:0]  c_reg_cause = 5'd13;
    localparam logic [4:0]  c_reg_epc   = 5'd14;

    localparam int          c_sr_im_hi  = 15;
    localparam int          c_sr_im_lo  = 10;
    localparam int          c_sr_exl    = 1;
    localparam int          c_sr_ie     = 0;

    localparam int          c_cause_bd    = 31;
    localparam int          c_cause_ip_hi = 15;
    localparam int          c_cause_ip_lo = 10;
    localparam int          c_cause_ec_hi = 6;
    localparam int          c_cause_ec_lo = 2;

    localparam logic [31:0] c_ebase     = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
//  Module      : cp0_unit
//  Description : CP0 with SR/Cause/EPC, interrupt/exception request and eret.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] EBase
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused_vpc;

    // EXL masks both sources, so no nested entry is possible.
    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
    assign Req       = w_int_req | w_exc_req;

    assign EPCOut       = r_epc - 32'd4;
    assign EBase        = c_ebase;
    assign w_unused_vpc = ^VPC[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_bd  <= 1'b0;
            r_ip  <= '0;
            r_exc <= '0;
            r_epc <= '0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                r_exl <= 1'b1;
                r_exc <= w_int_req ? 5'(EXC_INT) : ExcCodeIn;
                r_bd  <= BDIn;
                r_epc <= word_align(VPC) - (BDIn ? 32'd4 : 32'd0);
            end else begin
                if (EXLClr) begin
                    r_exl <= 1'b0;
                end
                // A simultaneous mtc0 to SR overrides the eret clear.
                if (WE && (A2 == c_reg_sr)) begin
                    r_im  <= DIn[c_sr_im_hi:c_sr_im_lo];
                    r_exl <= DIn[c_sr_exl];
                    r_ie  <= DIn[c_sr_ie];
                end
                if (WE && (A2 == c_reg_epc)) begin
                    r_epc <= word_align(DIn);
                end
            end
        end
    end

    always_comb begin
        w_sr                             = '0;
        w_sr[c_sr_im_hi:c_sr_im_lo]      = r_im;
        w_sr[c_sr_exl]                   = r_exl;
        w_sr[c_sr_ie]                    = r_ie;
        w_cause                          = '0;
        w_cause[c_cause_bd]              = r_bd;
        w_cause[c_cause_ip_hi:c_cause_ip_lo] = r_ip;
        w_cause[c_cause_ec_hi:c_cause_ec_lo] = r_exc;
    end

    always_comb begin
        DOut = '0;
        case (A1)
            c_reg_sr:    DOut = w_sr;
            c_reg_cause: DOut = w_cause;
            c_reg_epc:   DOut = r_epc;
            default:     DOut = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cp0_unit.sv
// ============================================================================
//  Module      : tb_cp0_unit
//  Description : Directed and randomized self-checking bench for cp0_unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] DIn, VPC;
    logic        WE, BDIn, EXLClr;
    logic [5:0]  HWInt;
    logic [31:0] DOut, EPCOut, EBase;
    logic        Req;

    int n_vec = 0;
    int n_err = 0;

    // reference state, kept as architectural fields
    logic [5:0]  m_im, m_ip;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_exc;
    logic [31:0] m_epc;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .DOut(DOut), .Req(Req), .EPCOut(EPCOut), .EBase(EBase)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = '0; m_epc = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'h0, m_ip, 3'h0, m_exc, 2'h0};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_req();
        logic irq, exc;
        irq = (((HWInt & m_im) != 6'd0) && m_ie && !m_exl);
        exc = ((ExcCodeIn != 5'd0) && !m_exl);
        return irq || exc;
    endfunction

    task automatic model_edge();
        logic irq;
        if (!reset) return;
        irq = (((HWInt & m_im) != 6'd0) && m_ie && !m_exl);
        if (m_req()) begin
            m_exl = 1'b1;
            m_exc = irq ? 5'd0 : ExcCodeIn;
            m_bd  = BDIn;
            m_epc = (VPC & 32'hFFFF_FFFC) - (BDIn ? 32'd4 : 32'd0);
        end else begin
            if (EXLClr) m_exl = 1'b0;
            if (WE && A2 == 5'd12) begin
                m_im  = DIn[15:10];
                m_exl = DIn[1];
                m_ie  = DIn[0];
            end
            if (WE && A2 == 5'd14) m_epc = DIn & 32'hFFFF_FFFC;
        end
        m_ip = HWInt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
        chk({tag, "_model"}, DOut, m_read(a));
    endtask

    initial begin
        model_clear();
        reset = 0; A1 = 0; A2 = 0; DIn = 0; WE = 0; VPC = 0; BDIn = 0;
        ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
        #1;
        // reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        chk("rst_epcout", EPCOut, 32'hFFFF_FFFC);
        chk("rst_req", {31'h0, Req}, 32'h0);
        chk("ebase", EBase, 32'h0000_4180);
        tick();

        // mtc0 SR = 0x401, then interrupt line 0
        reset = 1; WE = 1; A2 = 5'd12; DIn = 32'h0000_0401;
        #1 chk("mtc0_req", {31'h0, Req}, 32'h0);
        tick();
        WE = 0; HWInt = 6'b000001; VPC = 32'h3010;
        rd("sr_written", 5'd12, 32'h0000_0401);
        chk("irq_req", {31'h0, Req}, 32'h1);
        tick();
        HWInt = 0;
        rd("irq_sr", 5'd12, 32'h0000_0403);
        rd("irq_cause", 5'd13, 32'h0000_0400);
        rd("irq_epc", 5'd14, 32'h0000_3010);
        chk("irq_epcout", EPCOut, 32'h0000_300C);
        chk("irq_req_drop", {31'h0, Req}, 32'h0);
        tick();

        // EXL masks an RI exception
        ExcCodeIn = 5'd10;
        #1 chk("exl_mask_req", {31'h0, Req}, 32'h0);
        tick();
        rd("exl_sr_hold", 5'd12, 32'h0000_0403);
        rd("exl_epc_hold", 5'd14, 32'h0000_3010);
        EXLClr = 1;
        #1 chk("eret_req", {31'h0, Req}, 32'h0);
        tick();
        EXLClr = 0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        chk("pending_exc_req", {31'h0, Req}, 32'h1);

        // overflow in delay slot
        ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h3024;
        #1 chk("ov_req", {31'h0, Req}, 32'h1);
        tick();
        ExcCodeIn = 0; BDIn = 0;
        rd("ov_cause", 5'd13, 32'h8000_0030);
        rd("ov_epc", 5'd14, 32'h0000_3020);
        EXLClr = 1;
        tick();
        EXLClr = 0;

        // mtc0 EPC loses to a same-cycle request
        WE = 1; A2 = 5'd14; DIn = 32'h5000; ExcCodeIn = 5'd4; VPC = 32'h3008;
        #1 chk("we_req_req", {31'h0, Req}, 32'h1);
        tick();
        WE = 0; ExcCodeIn = 0;
        rd("we_req_epc", 5'd14, 32'h0000_3008);
        EXLClr = 1;
        tick();
        EXLClr = 0;

        // reset mid-cycle during a request
        ExcCodeIn = 5'd5; VPC = 32'h3100;
        #1 chk("pre_rst_req", {31'h0, Req}, 32'h1);
        #1 reset = 0;
        model_clear();
        rd("mid_rst_sr", 5'd12, 32'h0);
        rd("mid_rst_cause", 5'd13, 32'h0);
        rd("mid_rst_epc", 5'd14, 32'h0);
        ExcCodeIn = 0;
        #1 chk("mid_rst_req", {31'h0, Req}, 32'h0);
        chk("mid_rst_epcout", EPCOut, 32'hFFFF_FFFC);
        tick();
        rd("rst_edge_epc", 5'd14, 32'h0);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [4:0] pick [4];
            reset     = 1;
            pick[0] = 5'd12; pick[1] = 5'd13; pick[2] = 5'd14; pick[3] = 5'($urandom);
            VPC       = $urandom;
            BDIn      = 1'($urandom);
            HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            ExcCodeIn = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            WE        = ($urandom_range(0, 2) == 0);
            A2        = pick[$urandom_range(0, 3)];
            DIn       = $urandom;
            EXLClr    = ($urandom_range(0, 3) == 0);
            A1        = pick[$urandom_range(0, 3)];
            #1;
            chk("rnd_req", {31'h0, Req}, {31'h0, m_req()});
            chk("rnd_epcout", EPCOut, m_epc - 32'd4);
            chk("rnd_dout", DOut, m_read(A1));
            if ($urandom_range(0, 29) == 0) begin
                #1 reset = 0;
                model_clear();
                #1 chk("rnd_rst_dout", DOut, m_read(A1));
                chk("rnd_rst_epcout", EPCOut, 32'hFFFF_FFFC);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
